// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the shift-add multiplier
package mult_pkg;
  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam int ITER_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mult_adder.sv
// rtl/mult_adder.sv - unsigned adder with carry-out feeding the product register
module mult_adder import mult_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencer, multiplicand register and adder for the shift-add multiplier
module mult_control import mult_pkg::*; #(
  parameter int WIDTH  = mult_pkg::WIDTH,
  parameter int ITER_W = mult_pkg::ITER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic             lsb,
  input  logic [WIDTH-1:0] alusrc2,
  output logic             run,
  output logic             srtctrl,
  output logic             wrctrl,
  output logic [WIDTH-1:0] alu_o,
  output logic             overflow,
  output logic             ready,
  output logic             busy
);
  state_t             state, state_nxt;
  logic [ITER_W-1:0]  cnt;
  logic [WIDTH-1:0]   mcand;
  logic               accept;
  logic               last_iter;

  // start is only honoured when no multiply is in flight
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_iter = (cnt == ITER_W'(ITERATIONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand <= multiplicand_i;
        cnt   <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    srtctrl   = 1'b0;
    wrctrl    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        run       = 1'b1;
        busy      = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        srtctrl = 1'b1;
        wrctrl  = lsb;
        busy    = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (accept) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mult_adder #(.W(WIDTH)) u_adder (
    .a     (alusrc2),
    .b     (mcand),
    .sum   (alu_o),
    .carry (overflow)
  );
endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - scoreboard bench with a behavioural product register
module tb_mult_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        run, srtctrl, wrctrl, overflow, ready, busy;
  logic [31:0] alu_o;
  logic [63:0] prod;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] sb[$];
  int last_lat, run_c, srt_c, wr_c;
  bit ovf_seen;

  always #5 clk = ~clk;

  mult_control dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .multiplicand_i (multiplicand),
    .lsb            (prod[0]),
    .alusrc2        (prod[63:32]),
    .run            (run),
    .srtctrl        (srtctrl),
    .wrctrl         (wrctrl),
    .alu_o          (alu_o),
    .overflow       (overflow),
    .ready          (ready),
    .busy           (busy)
  );

  // product register the controller drives
  always @(posedge clk or posedge rst) begin
    if (rst) prod <= '0;
    else if (run) prod <= {32'b0, multiplier};
    else if (srtctrl) prod <= wrctrl ? {overflow, alu_o, prod[31:1]} : {1'b0, prod[63:1]};
  end

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [63:0] exp_p;
    @(posedge clk); #1;
    multiplicand = a; multiplier = b; start = 1'b1;
    sb.push_back({32'b0, a} * {32'b0, b});
    run_c = 0; srt_c = 0; wr_c = 0; ovf_seen = 0;
    @(posedge clk); #1;
    start = 1'b0; last_lat = 1;
    n_total++;
    if (run !== 1'b1 || ready !== 1'b0)
      $display("FAIL load_pulse: run=%b ready=%b, want run=1 ready=0", run, ready);
    else n_pass++;
    while (ready !== 1'b1 && last_lat < 60) begin
      if (run) run_c++;
      if (srtctrl) srt_c++;
      if (wrctrl) begin wr_c++; if (overflow) ovf_seen = 1; end
      if (inject && srtctrl && srt_c == 5) begin start = 1'b1; multiplicand = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      start = 1'b0; last_lat++;
    end
    exp_p = sb.pop_front();
    n_total++;
    if (ready !== 1'b1)
      $display("FAIL ready_timeout: ready=%b after %0d cycles, want 1", ready, last_lat);
    else if (prod !== exp_p)
      $display("FAIL product %0h*%0h: got %h, want %h", a, b, prod, exp_p);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    n_total++;
    if ({run, srtctrl, wrctrl, ready, busy, overflow} !== 6'b0 || alu_o !== prod[63:32])
      $display("FAIL reset_outputs: run=%b srt=%b wr=%b rdy=%b busy=%b ovf=%b alu=%h",
               run, srtctrl, wrctrl, ready, busy, overflow, alu_o);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || ready !== 1'b0)
      $display("FAIL idle_hold: busy=%b ready=%b, want 0 0", busy, ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_mult(32'd3, 32'd5, 0);
    n_total++;
    if (last_lat !== 34) $display("FAIL basic_latency: got %0d, want 34", last_lat); else n_pass++;
    n_total++;
    if (run_c !== 1) $display("FAIL basic_run_cycles: got %0d, want 1", run_c); else n_pass++;
    n_total++;
    if (srt_c !== 32) $display("FAIL basic_srt_cycles: got %0d, want 32", srt_c); else n_pass++;
  endtask

  task automatic test_max();
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    n_total++;
    if (!ovf_seen) $display("FAIL max_overflow: seen=%0d, want 1", ovf_seen); else n_pass++;
    n_total++;
    if (prod[63] !== 1'b1) $display("FAIL max_msb: got %b, want 1", prod[63]); else n_pass++;
  endtask

  task automatic test_zero();
    do_mult(32'h1234_5678, 32'd0, 0);
    n_total++;
    if (wr_c !== 0) $display("FAIL zero_wrctrl: got %0d cycles, want 0", wr_c); else n_pass++;
    n_total++;
    if (last_lat !== 34) $display("FAIL zero_latency: got %0d, want 34", last_lat); else n_pass++;
  endtask

  task automatic test_ignore_start();
    do_mult(32'd1000, 32'd77, 1);
    n_total++;
    if (last_lat !== 34) $display("FAIL ignore_latency: got %0d, want 34", last_lat); else n_pass++;
    n_total++;
    if (run_c !== 1) $display("FAIL ignore_run_cycles: got %0d, want 1", run_c); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    @(posedge clk); #1;
    multiplicand = 32'd3; multiplier = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 10 && !(srtctrl && cyc == 9)) begin
      if (srtctrl) cyc++;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1; #1;
    n_total++;
    if ({run, srtctrl, wrctrl, ready, busy, overflow} !== 6'b0 || alu_o !== prod[63:32])
      $display("FAIL midreset_outputs: run=%b srt=%b wr=%b rdy=%b busy=%b ovf=%b alu=%h",
               run, srtctrl, wrctrl, ready, busy, overflow, alu_o);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    do_mult(32'd7, 32'd9, 0);
    n_total++;
    if (prod !== 64'd63) $display("FAIL midreset_product: got %0d, want 63", prod); else n_pass++;
  endtask

  task automatic test_back_to_back();
    n_total++;
    if (ready !== 1'b1) $display("FAIL b2b_in_done: ready=%b, want 1", ready); else n_pass++;
    do_mult(32'd2, 32'h8000_0000, 0);
    n_total++;
    if (prod !== 64'h1_0000_0000) $display("FAIL b2b_product: got %h, want 100000000", prod);
    else n_pass++;
    n_total++;
    if (last_lat !== 34) $display("FAIL b2b_latency: got %0d, want 34", last_lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
